fm_demod_param: RTL and testbench

Parametrised FM discriminator that replaces the fixed-width fm_demod core. It sits after the I/Q mixer and low-pass FIR stage. It takes filtered baseband I/Q samples, computes the instantaneous frequency with a cross-product discriminator, and drives a scaled, saturated output stream. It also measures per-window peak deviation and modulation zero-crossing count, which downstream logic uses to derive mf, delta_f and mod_freq.

---
 rtl/fm_demod_param.sv | 195 +++++++++++++++++++
 tb/tb_fm_demod_param.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_demod_param.sv
// FM cross-product discriminator with saturated output stream and per-window
// peak-deviation / positive zero-crossing measurement.
module fm_demod_param #(
  parameter int unsigned DW       = 16,
  parameter int unsigned OW       = 16,
  parameter int unsigned SHIFT    = 14,
  parameter int unsigned WIN_LOG2 = 20,
  parameter int unsigned HYST     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 i_valid,
  input  logic signed [DW-1:0] i_data_i,
  input  logic signed [DW-1:0] i_data_q,
  output logic                 o_rdy,
  output logic signed [OW-1:0] o_data,
  output logic                 o_sat,
  output logic                 o_meas_valid,
  output logic signed [OW-1:0] o_dev_peak,
  output logic [WIN_LOG2:0]    o_zc_cnt
);

  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned DiffW = PW + 1;
  localparam logic signed [OW:0] HystP = (OW+1)'(HYST);
  localparam logic signed [OW:0] HystN = -HystP;

  typedef enum logic {StIdle, StRun} state_e;

  state_e state_q, state_d;
  logic   prime, accept;

  always_comb begin
    state_d = state_q;
    prime   = 1'b0;
    accept  = 1'b0;
    if (!en) begin
      state_d = StIdle;
    end else if (i_valid) begin
      unique case (state_q)
        StIdle: begin
          prime   = 1'b1;
          state_d = StRun;
        end
        StRun:   accept = 1'b1;
        default: state_d = StIdle;
      endcase
    end
  end

  logic signed [DW-1:0]    last_i_q, last_q_q;
  logic signed [DW-1:0]    prev_i_q, prev_q_q, cur_i_q, cur_q_q;
  logic                    s1_v_q, s2_v_q, s3_v_q;
  logic signed [PW-1:0]    p1_q, p2_q;
  logic signed [DiffW-1:0] diff, diff_m, s3_q;

  always_comb begin
    diff   = DiffW'(p1_q) - DiffW'(p2_q);
    diff_m = mode ? -diff : diff;
  end

  // last_* always holds the most recent accepted sample so the next one can pair with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_i_q <= '0;
      last_q_q <= '0;
      prev_i_q <= '0;
      prev_q_q <= '0;
      cur_i_q  <= '0;
      cur_q_q  <= '0;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s3_v_q   <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      s3_q     <= '0;
    end else begin
      state_q <= state_d;
      if (!en) begin
        s1_v_q <= 1'b0;
        s2_v_q <= 1'b0;
        s3_v_q <= 1'b0;
      end else begin
        s1_v_q <= accept;
        s2_v_q <= s1_v_q;
        s3_v_q <= s2_v_q;
        if (prime || accept) begin
          last_i_q <= i_data_i;
          last_q_q <= i_data_q;
        end
        if (accept) begin
          prev_i_q <= last_i_q;
          prev_q_q <= last_q_q;
          cur_i_q  <= i_data_i;
          cur_q_q  <= i_data_q;
        end
        if (s1_v_q) begin
          p1_q <= PW'(prev_i_q) * PW'(cur_q_q);
          p2_q <= PW'(prev_q_q) * PW'(cur_i_q);
        end
        if (s2_v_q) begin
          s3_q <= diff_m >>> SHIFT;
        end
      end
    end
  end

  // In range iff every bit from the OW-1 position upward equals the sign bit.
  logic [DiffW-OW:0]    s3_top;
  logic                 ovf;
  logic signed [OW-1:0] sat_val;

  assign s3_top  = s3_q[DiffW-1:OW-1];
  assign ovf     = !((&s3_top) || !(|s3_top));
  assign sat_val = s3_q[DiffW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdy  <= 1'b0;
      o_data <= '0;
      o_sat  <= 1'b0;
    end else if (!en) begin
      o_rdy <= 1'b0;
    end else begin
      o_rdy <= s3_v_q;
      if (s3_v_q) begin
        o_data <= ovf ? sat_val : s3_q[OW-1:0];
        o_sat  <= ovf;
      end
    end
  end

  logic [WIN_LOG2-1:0]  win_cnt_q;
  logic signed [OW-1:0] max_q, min_q, max_n, min_n;
  logic [WIN_LOG2:0]    zc_q, zc_n;
  logic                 hyst_high_q;
  logic                 win_first, win_last, rise, fall;
  logic signed [OW:0]   data_x, span;

  always_comb begin
    win_first = (win_cnt_q == '0);
    win_last  = &win_cnt_q;
    data_x    = {o_data[OW-1], o_data};
    max_n     = (win_first || (o_data > max_q)) ? o_data : max_q;
    min_n     = (win_first || (o_data < min_q)) ? o_data : min_q;
    rise      = !hyst_high_q && (data_x > HystP);
    fall      = hyst_high_q && (data_x < HystN);
    zc_n      = zc_q + (WIN_LOG2+1)'(rise);
    span      = {max_n[OW-1], max_n} - {min_n[OW-1], min_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q    <= '0;
      max_q        <= '0;
      min_q        <= '0;
      zc_q         <= '0;
      hyst_high_q  <= 1'b0;
      o_meas_valid <= 1'b0;
      o_dev_peak   <= '0;
      o_zc_cnt     <= '0;
    end else if (!en) begin
      win_cnt_q    <= '0;
      max_q        <= '0;
      min_q        <= '0;
      zc_q         <= '0;
      hyst_high_q  <= 1'b0;
      o_meas_valid <= 1'b0;
    end else begin
      o_meas_valid <= 1'b0;
      if (o_rdy) begin
        win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
        max_q     <= max_n;
        min_q     <= min_n;
        if (rise) begin
          hyst_high_q <= 1'b1;
        end else if (fall) begin
          hyst_high_q <= 1'b0;
        end
        if (win_last) begin
          o_meas_valid <= 1'b1;
          o_dev_peak   <= span[OW:1];
          o_zc_cnt     <= zc_n;
          zc_q         <= '0;
        end else begin
          zc_q <= zc_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_fm_demod_param.sv
// Randomised and directed bench for fm_demod_param against an arithmetic reference model.
module tb_fm_demod_param;
  localparam int DW = 16, OW = 16, SHIFT = 14, WL = 4, HYST = 4, WIN = 16;
  localparam longint MAXO = 32767, MINO = -32768;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0, i_valid = 1'b0;
  logic signed [DW-1:0] di = '0, dq = '0;
  logic o_rdy, o_sat, o_meas_valid;
  logic signed [OW-1:0] o_data, o_dev_peak;
  logic [WL:0] o_zc_cnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fm_demod_param #(.DW(DW), .OW(OW), .SHIFT(SHIFT), .WIN_LOG2(WL), .HYST(HYST)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .i_valid(i_valid),
    .i_data_i(di), .i_data_q(dq), .o_rdy(o_rdy), .o_data(o_data), .o_sat(o_sat),
    .o_meas_valid(o_meas_valid), .o_dev_peak(o_dev_peak), .o_zc_cnt(o_zc_cnt)
  );

  // Reference model: pending samples tagged with age in cycles since acceptance.
  typedef struct {int age; longint val;} pe_t;
  pe_t pipe[$];
  bit m_primed, m_high;
  longint m_pi, m_pq;
  int win_n, m_zc, m_max, m_min;
  bit exp_rdy, exp_sat, exp_meas;
  int exp_data, exp_peak, exp_zc;

  function automatic int ph_i(int ph, int a);
    case (ph & 3)
      0: return a;
      2: return -a;
      default: return 0;
    endcase
  endfunction

  function automatic int ph_q(int ph, int a);
    case (ph & 3)
      1: return a;
      3: return -a;
      default: return 0;
    endcase
  endfunction

  task automatic tick(input bit r, input bit e, input bit m, input bit v, input int xi, input int xq);
    pe_t h;
    longint d;
    rst = r; en = e; mode = m; i_valid = v;
    di = DW'(xi); dq = DW'(xq);
    @(posedge clk);
    #1;
    if (r) begin
      pipe.delete(); m_primed = 0; m_high = 0; m_pi = 0; m_pq = 0; win_n = 0; m_zc = 0;
      exp_rdy = 0; exp_sat = 0; exp_meas = 0; exp_data = 0; exp_peak = 0; exp_zc = 0;
    end else if (!e) begin
      pipe.delete(); m_primed = 0; m_high = 0; win_n = 0; m_zc = 0;
      exp_rdy = 0; exp_meas = 0;
    end else begin
      exp_meas = 0;
      if (exp_rdy) begin
        if (win_n == 0) begin
          m_max = exp_data; m_min = exp_data;
        end else begin
          if (exp_data > m_max) m_max = exp_data;
          if (exp_data < m_min) m_min = exp_data;
        end
        if (!m_high && exp_data > HYST) begin
          m_high = 1; m_zc++;
        end else if (m_high && exp_data < -HYST) begin
          m_high = 0;
        end
        win_n++;
        if (win_n == WIN) begin
          exp_peak = (m_max - m_min) / 2; exp_zc = m_zc; exp_meas = 1; win_n = 0; m_zc = 0;
        end
      end
      exp_rdy = 0;
      foreach (pipe[k]) pipe[k].age++;
      foreach (pipe[k]) begin
        if (pipe[k].age == 2) begin
          d = m ? -pipe[k].val : pipe[k].val;
          pipe[k].val = d >>> SHIFT;
        end
      end
      if (pipe.size() > 0 && pipe[0].age == 3) begin
        h = pipe.pop_front();
        exp_rdy = 1;
        exp_sat = (h.val > MAXO) || (h.val < MINO);
        exp_data = int'((h.val > MAXO) ? MAXO : (h.val < MINO) ? MINO : h.val);
      end
      if (v) begin
        if (m_primed) begin
          h.age = 0; h.val = m_pi * xq - m_pq * xi; pipe.push_back(h);
        end
        m_primed = 1; m_pi = xi; m_pq = xq;
      end
    end
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 1, 123, -45);
    checks++;
    if (o_rdy !== 0 || o_data !== 0 || o_sat !== 0 || o_meas_valid !== 0 ||
        o_dev_peak !== 0 || o_zc_cnt !== 0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b data=%0d sat=%b meas=%b peak=%0d zc=%0d want all 0",
               o_rdy, o_data, o_sat, o_meas_valid, o_dev_peak, o_zc_cnt);
    end
    tick(0, 1, 0, 1, 1000, 0);
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 0, 0, 0, 0);
      checks++;
      if (o_rdy !== 1'b0) begin
        failures++; $display("FAIL prime_no_output t=%0d got rdy=%b want 0", k, o_rdy);
      end
    end
  endtask

  task automatic test_rotation;
    int cm[5]   = '{0, 0, 1, 0, 0};
    int cdir[5] = '{1, -1, 1, 1, -1};
    int camp[5] = '{1000, 1000, 1000, 32767, 32767};
    int cwant[5] = '{61, -62, -62, 32767, -32768};
    int csat[5] = '{0, 0, 0, 1, 1};
    for (int c = 0; c < 5; c++) begin
      tick(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
        tick(0, 1, 1'(cm[c]), 1, ph_i(k * cdir[c], camp[c]), ph_q(k * cdir[c], camp[c]));
        checks++;
        if (o_rdy !== 1'(k >= 4)) begin
          failures++; $display("FAIL rot_latency case=%0d k=%0d got rdy=%b want %b", c, k, o_rdy, k >= 4);
        end
        if (k >= 4) begin
          checks++;
          if (o_data !== OW'(cwant[c]) || o_sat !== 1'(csat[c])) begin
            failures++;
            $display("FAIL rot_value case=%0d k=%0d got data=%0d sat=%b want data=%0d sat=%0d",
                     c, k, o_data, o_sat, cwant[c], csat[c]);
          end
        end
      end
    end
  endtask

  task automatic test_window;
    int ph = 0, nmeas = 0;
    tick(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 54; k++) begin
      if (k == 0 || k > 48) tick(0, 1, 0, (k == 0), ph_i(0, 1000), ph_q(0, 1000));
      else begin
        ph += ((k - 1) % 16 < 8) ? 1 : -1;
        tick(0, 1, 0, 1, ph_i(ph, 1000), ph_q(ph, 1000));
      end
      checks++;
      if (o_rdy !== exp_rdy || (exp_rdy && (o_data !== OW'(exp_data) || o_sat !== exp_sat))) begin
        failures++;
        $display("FAIL win_out k=%0d got rdy=%b data=%0d sat=%b want rdy=%b data=%0d sat=%b",
                 k, o_rdy, o_data, o_sat, exp_rdy, exp_data, exp_sat);
      end
      if (o_meas_valid) begin
        nmeas++;
        checks++;
        if (o_dev_peak !== 16'sd61 || o_zc_cnt !== 5'd1) begin
          failures++;
          $display("FAIL win_meas n=%0d got peak=%0d zc=%0d want peak=61 zc=1", nmeas, o_dev_peak, o_zc_cnt);
        end
      end
    end
    checks++;
    if (nmeas != 3) begin
      failures++; $display("FAIL win_pulses got %0d want 3", nmeas);
    end
  endtask

  task automatic test_hyst_band;
    int nmeas = 0;
    tick(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 22; k++) begin
      tick(0, 1, 0, (k <= 16), ph_i(k % 2, 200), ph_q(k % 2, 200));
      checks++;
      if (o_rdy !== exp_rdy || (exp_rdy && o_data !== OW'(exp_data))) begin
        failures++;
        $display("FAIL hyst_out k=%0d got rdy=%b data=%0d want rdy=%b data=%0d", k, o_rdy, o_data, exp_rdy, exp_data);
      end
      if (o_meas_valid) begin
        nmeas++;
        checks++;
        if (o_zc_cnt !== 5'd0 || o_dev_peak !== 16'sd2) begin
          failures++; $display("FAIL hyst_meas got zc=%0d peak=%0d want zc=0 peak=2", o_zc_cnt, o_dev_peak);
        end
      end
    end
    checks++;
    if (nmeas != 1) begin
      failures++; $display("FAIL hyst_pulses got %0d want 1", nmeas);
    end
  endtask

  task automatic test_rst_mid;
    int nrdy = 0, nmeas = 0;
    tick(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) tick(0, 1, 0, 1, ph_i(k, 1000), ph_q(k, 1000));
    tick(1, 1, 0, 1, ph_i(7, 1000), ph_q(7, 1000));
    checks++;
    if (o_rdy !== 0 || o_data !== 0 || o_sat !== 0 || o_meas_valid !== 0 ||
        o_dev_peak !== 0 || o_zc_cnt !== 0) begin
      failures++;
      $display("FAIL rst_mid_clear got rdy=%b data=%0d sat=%b meas=%b peak=%0d zc=%0d want all 0",
               o_rdy, o_data, o_sat, o_meas_valid, o_dev_peak, o_zc_cnt);
    end
    for (int k = 8; k < 37; k++) begin
      tick(0, 1, 0, (k < 32), ph_i(k, 1000), ph_q(k, 1000));
      checks++;
      if (o_rdy !== exp_rdy || (exp_rdy && o_data !== OW'(exp_data)) || o_meas_valid !== exp_meas) begin
        failures++;
        $display("FAIL rst_mid_out k=%0d got rdy=%b data=%0d meas=%b want rdy=%b data=%0d meas=%b",
                 k, o_rdy, o_data, o_meas_valid, exp_rdy, exp_data, exp_meas);
      end
      if (o_meas_valid) begin
        nmeas++;
        checks++;
        if (nrdy != 16) begin
          failures++; $display("FAIL rst_mid_window got %0d samples before pulse want 16", nrdy);
        end
      end
      if (o_rdy) nrdy++;
    end
    checks++;
    if (nrdy != 23 || nmeas != 1) begin
      failures++; $display("FAIL rst_mid_count got rdy=%0d meas=%0d want rdy=23 meas=1", nrdy, nmeas);
    end
  endtask

  task automatic test_en_drop;
    int ph = 0, nrdy = 0, nmeas = 0;
    tick(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 22; k++) begin
      if (k > 0) ph += ((k - 1) % 16 < 8) ? 1 : -1;
      tick(0, 1, 0, 1, ph_i(ph, 1000), ph_q(ph, 1000));
    end
    for (int k = 0; k < 2; k++) begin
      tick(0, 0, 0, 1, ph_i(ph + k, 1000), ph_q(ph + k, 1000));
      checks++;
      if (o_rdy !== 0 || o_meas_valid !== 0 || o_dev_peak !== 16'sd61 || o_zc_cnt !== 5'd1) begin
        failures++;
        $display("FAIL en_drop_hold k=%0d got rdy=%b meas=%b peak=%0d zc=%0d want 0 0 61 1",
                 k, o_rdy, o_meas_valid, o_dev_peak, o_zc_cnt);
      end
    end
    for (int k = 0; k < 28; k++) begin
      tick(0, 1, 0, (k < 23), ph_i(k, 1000), ph_q(k, 1000));
      checks++;
      if (o_rdy !== exp_rdy || (exp_rdy && o_data !== OW'(exp_data)) || o_meas_valid !== exp_meas) begin
        failures++;
        $display("FAIL en_drop_out k=%0d got rdy=%b data=%0d meas=%b want rdy=%b data=%0d meas=%b",
                 k, o_rdy, o_data, o_meas_valid, exp_rdy, exp_data, exp_meas);
      end
      if (o_meas_valid) begin
        nmeas++;
        checks++;
        if (nrdy != 16 || o_dev_peak !== 16'sd0 || o_zc_cnt !== 5'd1) begin
          failures++;
          $display("FAIL en_drop_window got n=%0d peak=%0d zc=%0d want n=16 peak=0 zc=1",
                   nrdy, o_dev_peak, o_zc_cnt);
        end
      end
      if (o_rdy) nrdy++;
    end
    checks++;
    if (nmeas != 1) begin
      failures++; $display("FAIL en_drop_pulses got %0d want 1", nmeas);
    end
  endtask

  task automatic test_random;
    bit m = 0;
    int a, xi, xq;
    tick(1, 0, 0, 0, 0, 0);
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(15) == 0) m = ~m;
      case ($urandom_range(2))
        0: a = 32767;
        1: a = 4000;
        default: a = 300;
      endcase
      xi = int'($urandom_range(2 * a)) - a;
      xq = int'($urandom_range(2 * a)) - a;
      tick(($urandom_range(399) == 0), ($urandom_range(99) != 0), m, ($urandom_range(3) != 0), xi, xq);
      checks++;
      if (o_rdy !== exp_rdy || (exp_rdy && (o_data !== OW'(exp_data) || o_sat !== exp_sat))) begin
        failures++;
        $display("FAIL rand_out t=%0d got rdy=%b data=%0d sat=%b want rdy=%b data=%0d sat=%b",
                 t, o_rdy, o_data, o_sat, exp_rdy, exp_data, exp_sat);
      end
      checks++;
      if (o_meas_valid !== exp_meas || o_dev_peak !== OW'(exp_peak) || o_zc_cnt !== (WL+1)'(exp_zc)) begin
        failures++;
        $display("FAIL rand_meas t=%0d got meas=%b peak=%0d zc=%0d want meas=%b peak=%0d zc=%0d",
                 t, o_meas_valid, o_dev_peak, o_zc_cnt, exp_meas, exp_peak, exp_zc);
      end
    end
  endtask

  initial begin
    test_reset;
    test_rotation;
    test_window;
    test_hyst_band;
    test_rst_mid;
    test_en_drop;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
